// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA pixel path: default active-area sizes, the
// packed colour struct, the fetch FSM state encoding and a small helper that
// builds the line-replication mask used by the fetcher.
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int H_ACTIVE_DEF    = 640;
    localparam int V_ACTIVE_DEF    = 480;
    localparam int COLOR_DEPTH_DEF = 8;

    typedef struct packed {
        logic [COLOR_DEPTH_DEF-1:0] r;
        logic [COLOR_DEPTH_DEF-1:0] g;
        logic [COLOR_DEPTH_DEF-1:0] b;
    } rgb_t;

    typedef enum logic [0:0] {
        WAIT_VBLANK = 1'b0,
        RUN         = 1'b1
    } fetch_state_e;

    // Low vcount bits that must all be ones on the last replicated copy of a
    // source line; zero bits wide (mask 0) when there is no replication.
    function automatic logic [9:0] scale_mask(input int shift);
        return 10'((32'sd1 <<< shift) - 32'sd1);
    endfunction

endpackage

// File: rtl/vga_valid_delay.sv
// ---------------------------------------------------------------------------
// vga_valid_delay
// Shift register that delays the fetch qualifier so it lines up with the
// RAM read data. DEPTH is RAM latency + 1, so it is always at least 2.
// Ports:
//   vga_clk  pixel clock
//   reset_n  asynchronous active-low clear
//   din      fetch qualifier entering the pipe
//   dout     qualifier delayed by DEPTH cycles
// ---------------------------------------------------------------------------
module vga_valid_delay
    import vga_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic vga_clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] shift_r;

    // Shift the qualifier one stage per pixel clock.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_r <= '0;
        end else begin
            shift_r <= {shift_r[DEPTH-2:0], din};
        end
    end

    assign dout = shift_r[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// ---------------------------------------------------------------------------
// vga_pixel_fetch
// Turns hcount/vcount into frame-RAM read addresses (with optional 2^N pixel
// replication), re-aligns the RAM data with a delayed data enable, and drives
// a fixed blank colour outside the displayed area. After reset nothing is
// fetched until vertical blanking is seen, so a torn frame is never shown.
// Ports:
//   vga_clk, reset_n       pixel clock, async active-low reset
//   hcount, vcount         timing generator position
//   addr, rd_en            frame RAM read request
//   data                   frame RAM read data, packed {r,g,b}
//   vga_r, vga_g, vga_b    registered colour outputs
//   de                     data enable aligned with the colour outputs
//   synced                 high once locked to frame timing
// ---------------------------------------------------------------------------
module vga_pixel_fetch
    import vga_pkg::*;
#(
    parameter int                       H_ACTIVE    = H_ACTIVE_DEF,
    parameter int                       V_ACTIVE    = V_ACTIVE_DEF,
    parameter int                       COLOR_DEPTH = COLOR_DEPTH_DEF,
    parameter int                       SCALE_SHIFT = 0,
    parameter int                       RAM_LATENCY = 1,
    parameter int                       ADDR_W      = 19,
    parameter logic [3*COLOR_DEPTH-1:0] BLANK_COLOR = '0
) (
    input  logic                     vga_clk,
    input  logic                     reset_n,
    input  logic [9:0]               hcount,
    input  logic [9:0]               vcount,
    output logic [ADDR_W-1:0]        addr,
    output logic                     rd_en,
    input  logic [3*COLOR_DEPTH-1:0] data,
    output logic [COLOR_DEPTH-1:0]   vga_r,
    output logic [COLOR_DEPTH-1:0]   vga_g,
    output logic [COLOR_DEPTH-1:0]   vga_b,
    output logic                     de,
    output logic                     synced
);

    localparam logic [0:0]        ST_WAIT_VBLANK = WAIT_VBLANK;
    localparam logic [0:0]        ST_RUN         = RUN;
    localparam logic [9:0]        H_ACT_W        = 10'(H_ACTIVE);
    localparam logic [9:0]        V_ACT_W        = 10'(V_ACTIVE);
    localparam logic [9:0]        H_LAST         = 10'(H_ACTIVE - 1);
    localparam logic [9:0]        V_MASK         = scale_mask(SCALE_SHIFT);
    localparam logic [ADDR_W-1:0] LINE_STEP      = ADDR_W'(H_ACTIVE >> SCALE_SHIFT);

    logic                     h_active_s;
    logic                     v_active_s;
    logic                     fetch_s;
    logic                     line_end_s;
    logic                     valid_dly_s;
    logic [0:0]               state_r;
    logic [0:0]               state_nxt_s;
    logic [ADDR_W-1:0]        line_base_r;
    logic [ADDR_W-1:0]        addr_nxt_s;
    logic [ADDR_W-1:0]        addr_r;
    logic                     rd_en_r;
    logic [3*COLOR_DEPTH-1:0] pix_r;
    logic                     de_r;

    // Active-area decode, fetch qualifier and next address.
    always_comb begin
        h_active_s = (hcount < H_ACT_W);
        v_active_s = (vcount < V_ACT_W);
        fetch_s    = h_active_s && v_active_s && (state_r == ST_RUN);
        // Advance the line base only after the last replicated copy of a line.
        line_end_s = fetch_s && (hcount == H_LAST) && ((vcount & V_MASK) == V_MASK);
        addr_nxt_s = line_base_r + ADDR_W'(hcount >> SCALE_SHIFT);
    end

    // Next-state logic: lock to the frame on the first blanking line.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_WAIT_VBLANK: begin
                if (!v_active_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_WAIT_VBLANK;
                end
            end
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_WAIT_VBLANK;
        endcase
    end

    // FSM state register.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_WAIT_VBLANK;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Start address of the current source line, restarted in vertical blank.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            line_base_r <= '0;
        end else if (!v_active_s) begin
            line_base_r <= '0;
        end else if (line_end_s) begin
            line_base_r <= line_base_r + LINE_STEP;
        end else begin
            line_base_r <= line_base_r;
        end
    end

    // RAM read request; the address holds when not fetching.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_r  <= '0;
            rd_en_r <= 1'b0;
        end else begin
            if (fetch_s) begin
                addr_r <= addr_nxt_s;
            end else begin
                addr_r <= addr_r;
            end
            rd_en_r <= fetch_s;
        end
    end

    vga_valid_delay #(
        .DEPTH (RAM_LATENCY + 1)
    ) u_valid_delay (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .din     (fetch_s),
        .dout    (valid_dly_s)
    );

    // Output register: RAM data when the aligned valid is set, else blank.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_r <= BLANK_COLOR;
            de_r  <= 1'b0;
        end else if (valid_dly_s) begin
            pix_r <= data;
            de_r  <= 1'b1;
        end else begin
            pix_r <= BLANK_COLOR;
            de_r  <= 1'b0;
        end
    end

    assign addr                  = addr_r;
    assign rd_en                 = rd_en_r;
    assign {vga_r, vga_g, vga_b} = pix_r;
    assign de                    = de_r;
    assign synced                = (state_r == ST_RUN);

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// ---------------------------------------------------------------------------
// tb_vga_pixel_fetch
// Four fetcher instances share one compressed hcount/vcount stream (a handful
// of columns per line, every line visited, column H_ACTIVE-1 always present).
//   cfg0: SCALE_SHIFT=0, RAM_LATENCY=1, blank 0,        RAM = address
//   cfg1: SCALE_SHIFT=1, RAM_LATENCY=1, blank 0,        RAM = address
//   cfg2: SCALE_SHIFT=0, RAM_LATENCY=3, blank 102030,   RAM = address
//   cfg3: SCALE_SHIFT=2, RAM_LATENCY=2, blank 0A0B0C,   RAM = hashed address
// Expected addresses come from (v>>s)*(640>>s)+(h>>s); expected pixels are
// held in a short per-config history and compared RAM_LATENCY+1 steps later.
// ---------------------------------------------------------------------------
module tb_vga_pixel_fetch;

    localparam int N_CFG = 4;

    logic       vga_clk;
    logic       reset_n = 1'b1;
    logic [9:0] hcount  = 10'd0;
    logic [9:0] vcount  = 10'd0;

    logic [18:0] addr_w   [N_CFG];
    logic        rd_en_w  [N_CFG];
    logic [23:0] data_w   [N_CFG];
    logic [7:0]  r_w      [N_CFG];
    logic [7:0]  g_w      [N_CFG];
    logic [7:0]  b_w      [N_CFG];
    logic        de_w     [N_CFG];
    logic        synced_w [N_CFG];

    int n_checks = 0;
    int n_fail   = 0;

    logic        exp_run;
    logic [18:0] exp_addr [N_CFG];
    logic [24:0] hist     [N_CFG][8];
    int          fill_cnt;

    function automatic int scale_of(input int g);
        return (g == 1) ? 1 : ((g == 3) ? 2 : 0);
    endfunction

    function automatic int lat_of(input int g);
        return (g == 2) ? 3 : ((g == 3) ? 2 : 1);
    endfunction

    function automatic logic [23:0] blank_of(input int g);
        return (g == 2) ? 24'h102030 : ((g == 3) ? 24'h0A0B0C : 24'h000000);
    endfunction

    function automatic logic [23:0] ram_val(input int g, input logic [18:0] a);
        logic [31:0] x;
        if (g == 3) begin
            x = {13'd0, a} * 32'h9E3779B1;
            x = x ^ (x >> 15);
            return x[23:0];
        end else begin
            return {5'd0, a};
        end
    endfunction

    initial begin
        vga_clk = 1'b0;
        forever #5 vga_clk = ~vga_clk;
    end

    for (genvar gi = 0; gi < N_CFG; gi++) begin : gen_dut
        logic [23:0] ram_pipe [3] = '{24'd0, 24'd0, 24'd0};

        vga_pixel_fetch #(
            .H_ACTIVE    (640),
            .V_ACTIVE    (480),
            .COLOR_DEPTH (8),
            .SCALE_SHIFT (scale_of(gi)),
            .RAM_LATENCY (lat_of(gi)),
            .ADDR_W      (19),
            .BLANK_COLOR (blank_of(gi))
        ) u_dut (
            .vga_clk (vga_clk),
            .reset_n (reset_n),
            .hcount  (hcount),
            .vcount  (vcount),
            .addr    (addr_w[gi]),
            .rd_en   (rd_en_w[gi]),
            .data    (data_w[gi]),
            .vga_r   (r_w[gi]),
            .vga_g   (g_w[gi]),
            .vga_b   (b_w[gi]),
            .de      (de_w[gi]),
            .synced  (synced_w[gi])
        );

        // Behavioural frame RAM with a read pipeline of RAM_LATENCY stages.
        always @(posedge vga_clk) begin
            if (rd_en_w[gi]) begin
                ram_pipe[0] <= ram_val(gi, addr_w[gi]);
            end
            ram_pipe[1] <= ram_pipe[0];
            ram_pipe[2] <= ram_pipe[1];
        end

        assign data_w[gi] = ram_pipe[lat_of(gi) - 1];
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Apply one (h,v) sample, advance one clock and check every instance.
    task automatic step(input int h, input int v);
        logic        fetch;
        int          s;
        int          lat;
        logic [18:0] ea;
        hcount = 10'(h);
        vcount = 10'(v);
        fetch  = (h < 640) && (v < 480) && exp_run;
        for (int g = 0; g < N_CFG; g++) begin
            s  = scale_of(g);
            ea = 19'(((v >> s) * (640 >> s)) + (h >> s));
            for (int i = 7; i > 0; i--) hist[g][i] = hist[g][i-1];
            if (fetch) begin
                exp_addr[g] = ea;
                hist[g][0]  = {1'b1, ram_val(g, ea)};
            end else begin
                hist[g][0]  = {1'b0, blank_of(g)};
            end
        end
        if (v >= 480) exp_run = 1'b1;
        @(posedge vga_clk);
        #1;
        fill_cnt++;
        for (int g = 0; g < N_CFG; g++) begin
            lat = lat_of(g);
            check_eq($sformatf("cfg%0d rd_en (%0d,%0d)", g, h, v), 32'(rd_en_w[g]), 32'(fetch));
            check_eq($sformatf("cfg%0d addr (%0d,%0d)", g, h, v), 32'(addr_w[g]), 32'(exp_addr[g]));
            check_eq($sformatf("cfg%0d synced (%0d,%0d)", g, h, v), 32'(synced_w[g]), 32'(exp_run));
            if (fill_cnt > lat + 1) begin
                check_eq($sformatf("cfg%0d de (%0d,%0d)", g, h, v),
                         32'(de_w[g]), 32'(hist[g][lat+1][24]));
                check_eq($sformatf("cfg%0d rgb (%0d,%0d)", g, h, v),
                         32'({r_w[g], g_w[g], b_w[g]}), 32'(hist[g][lat+1][23:0]));
            end
        end
    endtask

    // Assert reset asynchronously, check reset values, release after an edge.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        for (int g = 0; g < N_CFG; g++) begin
            check_eq($sformatf("cfg%0d rst addr", g), 32'(addr_w[g]), 32'd0);
            check_eq($sformatf("cfg%0d rst rd_en", g), 32'(rd_en_w[g]), 32'd0);
            check_eq($sformatf("cfg%0d rst de", g), 32'(de_w[g]), 32'd0);
            check_eq($sformatf("cfg%0d rst rgb", g), 32'({r_w[g], g_w[g], b_w[g]}), 32'(blank_of(g)));
            check_eq($sformatf("cfg%0d rst synced", g), 32'(synced_w[g]), 32'd0);
        end
        @(posedge vga_clk);
        #1;
        reset_n  = 1'b1;
        exp_run  = 1'b0;
        fill_cnt = 0;
        for (int g = 0; g < N_CFG; g++) exp_addr[g] = 19'd0;
    endtask

    task automatic vblank(input int n);
        for (int i = 0; i < n; i++) begin
            step(700, 500);
            check_eq("cfg0 line_base vblank", 32'(gen_dut[0].u_dut.line_base_r), 32'd0);
        end
    endtask

    // One compressed frame; optionally reset at (100,200).
    task automatic run_frame(input logic reset_mid);
        int hlist [10];
        int h;
        hlist = '{0, 1, 2, 3, 5, 6, 100, 638, 639, 640};
        for (int v = 0; v < 480; v++) begin
            for (int i = 0; i < 10; i++) begin
                h = hlist[i];
                if (reset_mid && v == 200 && h == 100) begin
                    hcount = 10'(h);
                    vcount = 10'(v);
                    do_reset();
                end else begin
                    step(h, v);
                    if (exp_run && h == 5 && v == 2)
                        check_eq("cfg0 addr pix(5,2)", 32'(addr_w[0]), 32'd1285);
                    if (exp_run && h < 2 && v < 2)
                        check_eq("cfg1 addr replicated 0", 32'(addr_w[1]), 32'd0);
                    if (exp_run && h == 2 && v == 2)
                        check_eq("cfg1 addr pix(2,2)", 32'(addr_w[1]), 32'd321);
                    if (exp_run && h == 639 && v == 479) begin
                        check_eq("cfg0 last addr", 32'(addr_w[0]), 32'd307199);
                        check_eq("cfg1 last addr", 32'(addr_w[1]), 32'd76799);
                        check_eq("cfg3 last addr", 32'(addr_w[3]), 32'd19199);
                    end
                end
            end
        end
    endtask

    initial begin
        exp_run  = 1'b0;
        fill_cnt = 0;
        for (int g = 0; g < N_CFG; g++) exp_addr[g] = 19'd0;
        #1;
        do_reset();
        // Active samples before any vertical blank must not fetch.
        step(0, 0);
        step(1, 0);
        step(2, 0);
        vblank(3);
        run_frame(1'b0);
        vblank(3);
        run_frame(1'b1);
        vblank(3);
        run_frame(1'b0);
        vblank(8);
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
